// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit write-only LCD bus sequencer: timed power-up, fixed init
// command list, then one timed setup/E-pulse/hold/execute transaction per request.
module lcd_ctrl #(
  parameter int unsigned POWERUP_CYC = 1500000,
  parameter int unsigned SETUP_CYC   = 5,
  parameter int unsigned E_CYC       = 25,
  parameter int unsigned HOLD_CYC    = 5,
  parameter int unsigned EXEC_CYC    = 4000,
  parameter int unsigned CLEAR_CYC   = 160000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > E_CYC) ? EXEC_CYC : E_CYC;
  localparam int unsigned MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, EXEC, IDLE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, lim;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               e_d, rs_d, ready_d, done_d;
  logic [7:0]         data_d;
  logic               is_clear, cnt_last;

  // Fixed power-on command list: function set, display on, entry mode, clear.
  function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign lcd_rw   = 1'b0;
  // Clear and home (0x01..0x03) need the long execute wait.
  assign is_clear = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data != 8'd0);

  always_comb begin
    lim = '0;
    case (state)
      PWRUP:   lim = CNT_W'(POWERUP_CYC - 1);
      SETUP:   lim = CNT_W'(SETUP_CYC - 1);
      PULSE:   lim = CNT_W'(E_CYC - 1);
      HOLD:    lim = CNT_W'(HOLD_CYC - 1);
      EXEC:    lim = is_clear ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(EXEC_CYC - 1);
      default: lim = '0;
    endcase
  end

  assign cnt_last = (cnt == lim);

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    idx_d   = idx;
    e_d     = lcd_e;
    rs_d    = lcd_rs;
    data_d  = lcd_data;
    ready_d = o_ready;
    done_d  = o_init_done;
    case (state)
      PWRUP: if (cnt_last) begin
        state_d = SETUP;
        cnt_d   = '0;
        rs_d    = 1'b0;
        data_d  = init_cmd(idx);
      end
      SETUP: if (cnt_last) begin
        state_d = PULSE;
        cnt_d   = '0;
        e_d     = 1'b1;
      end
      PULSE: if (cnt_last) begin
        state_d = HOLD;
        cnt_d   = '0;
        e_d     = 1'b0;
      end
      HOLD: if (cnt_last) begin
        state_d = EXEC;
        cnt_d   = '0;
      end
      EXEC: if (cnt_last) begin
        cnt_d = '0;
        if (!o_init_done && (idx != IDX_W'(3))) begin
          idx_d   = idx + IDX_W'(1);
          rs_d    = 1'b0;
          data_d  = init_cmd(idx + IDX_W'(1));
          state_d = SETUP;
        end else begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (i_req && o_ready) begin
          rs_d    = i_rs;
          data_d  = i_data;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = '0;
        e_d     = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PWRUP;
      cnt         <= '0;
      idx         <= '0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      o_ready     <= 1'b0;
      o_init_done <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      lcd_e       <= e_d;
      lcd_rs      <= rs_d;
      lcd_data    <= data_d;
      o_ready     <= ready_d;
      o_init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected E-pulses are queued when stimulus is
// driven and popped by a monitor on each observed rising edge of lcd_e.
`timescale 1ns/100ps
module tb_lcd_ctrl;

  localparam int unsigned PW = 20, SU = 2, EC = 4, HC = 2, EX = 10, CL = 30;
  localparam int unsigned XFER = SU + EC + HC;

  typedef struct packed {
    logic        rs;
    logic [7:0]  data;
    logic [31:0] rise;
  } exp_t;

  logic        clk, rst, i_req, i_rs;
  logic [7:0]  i_data;
  logic        o_ready, o_init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc;
  logic [31:0] rise_cyc = 32'd0;
  logic        prev_e   = 1'b0;
  logic        seen_42  = 1'b0;

  logic [7:0]  cmd_tab [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h00, 8'h01};
  logic        rs_tab  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int unsigned lat_tab [7] = '{XFER + CL, XFER + CL, XFER + CL, XFER + EX,
                               XFER + EX, XFER + EX, XFER + EX};

  lcd_ctrl #(
    .POWERUP_CYC(PW), .SETUP_CYC(SU), .E_CYC(EC),
    .HOLD_CYC(HC), .EXEC_CYC(EX), .CLEAR_CYC(CL)
  ) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_rs(i_rs), .i_data(i_data),
    .o_ready(o_ready), .o_init_done(o_init_done), .lcd_data(lcd_data),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  initial begin
    clk = 1'b0;
    forever #0.5 clk = ~clk;
  end

  // Rising edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 32'd0;
    else      cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // E-pulse monitor: data, rs, rise cycle and width against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      prev_e <= 1'b0;
    end else begin
      if (lcd_data == 8'h42) seen_42 <= 1'b1;
      if (lcd_e && !prev_e) begin
        rise_cyc <= cyc;
        if (exp_q.size() == 0) begin
          check("extra_pulse", 32'(exp_q.size()), 32'd1);
        end else begin
          check("pulse_data",  32'(lcd_data), 32'(exp_q[0].data));
          check("pulse_rs",    32'(lcd_rs),   32'(exp_q[0].rs));
          check("pulse_cycle", cyc,           exp_q[0].rise);
          check("pulse_rw",    32'(lcd_rw),   32'd0);
          void'(exp_q.pop_front());
        end
      end
      if (!lcd_e && prev_e) check("pulse_width", cyc - rise_cyc, 32'(EC));
      prev_e <= lcd_e;
    end
  end

  // Called at a negedge; leaves i_req asserted and returns at the negedge after acceptance.
  task automatic send(input logic rs, input logic [7:0] d, output logic [31:0] acc);
    exp_t e;
    int   n = 0;
    i_req  = 1'b1;
    i_rs   = rs;
    i_data = d;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(o_ready), 32'd1);
    acc    = cyc + 32'd1;
    e.rs   = rs;
    e.data = d;
    e.rise = acc + 32'(SU);
    exp_q.push_back(e);
    @(negedge clk);
    check("latch_rs",   32'(lcd_rs),   32'(rs));
    check("latch_data", 32'(lcd_data), 32'(d));
    check("ready_drop", 32'(o_ready),  32'd0);
  endtask

  task automatic wait_ready(input string tag, input logic [31:0] acc, input int unsigned lat);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, cyc - acc, 32'(lat));
  endtask

  task automatic do_reset();
    exp_t e;
    logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    int n = 0;
    rst   = 1'b0;
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_e",     32'(lcd_e),       32'd0);
    check("rst_rs",    32'(lcd_rs),      32'd0);
    check("rst_data",  32'(lcd_data),    32'd0);
    check("rst_rw",    32'(lcd_rw),      32'd0);
    check("rst_ready", 32'(o_ready),     32'd0);
    check("rst_done",  32'(o_init_done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      e.rs   = 1'b0;
      e.data = init_tab[k];
      e.rise = 32'(PW + SU + k * (XFER + EX));
      exp_q.push_back(e);
    end
    rst = 1'b1;
    while (!o_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("init_ready_cycle", cyc, 32'(PW + 3 * (XFER + EX) + XFER + CL));
    check("init_done",        32'(o_init_done), 32'd1);
    check("init_pulses_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] acc, acc2;
    int n;
    rst    = 1'b1;
    i_req  = 1'b0;
    i_rs   = 1'b0;
    i_data = 8'h00;
    #0.2;
    do_reset();

    // Data write with a stray request while busy.
    send(1'b1, 8'h41, acc);
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_req  = 1'b1;
    i_rs   = 1'b1;
    i_data = 8'h42;
    @(negedge clk);
    i_req = 1'b0;
    wait_ready("ready_data", acc, XFER + EX);
    check("busy_pulses_left", 32'(exp_q.size()), 32'd0);

    // Command latency table: clear/home vs normal execute wait.
    for (int i = 0; i < 7; i++) begin
      send(rs_tab[i], cmd_tab[i], acc);
      i_req = 1'b0;
      wait_ready("ready_cmd", acc, lat_tab[i]);
    end

    // Back-to-back with i_req held high.
    send(1'b1, 8'h31, acc);
    send(1'b1, 8'h32, acc2);
    i_req = 1'b0;
    check("b2b_gap", acc2 - acc, 32'(XFER + EX + 1));
    wait_ready("ready_b2b", acc2, XFER + EX);

    // Reset asserted while lcd_e is high.
    send(1'b1, 8'h48, acc);
    i_req = 1'b0;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_pulse_seen", 32'(lcd_e), 32'd1);
    #0.2 rst = 1'b0;
    #0.1;
    check("async_e",     32'(lcd_e),       32'd0);
    check("async_ready", 32'(o_ready),     32'd0);
    check("async_done",  32'(o_init_done), 32'd0);
    @(negedge clk);
    do_reset();

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_0x42",     32'(seen_42),      32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
